// File: rtl/lsu_split_if.sv
// Bundles the MEM-stage request/response and the data-memory port of lsu_split.
// slave = the access unit itself, master = pipeline plus data memory.
interface lsu_split_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        dm_we;
    logic [2:0]  dm_type;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata, dm_dout,
        output stall, resp_valid, resp_rdata, dm_we, dm_type, dm_addr, dm_din
    );

    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata, dm_dout,
        input  stall, resp_valid, resp_rdata, dm_we, dm_type, dm_addr, dm_din
    );
endinterface

// File: rtl/lsu_split.sv
// MEM-stage load/store unit: aligned accesses pass straight through, misaligned
// halfword/word accesses are split into stalled byte accesses and reassembled.
module lsu_split #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    lsu_split_if.slave       bus,
    output logic [CNT_W-1:0] misalign_cnt
);
    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPLIT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       k_reg;
    logic             lat_we_reg;
    logic [2:0]       lat_type_reg;
    logic [31:0]      lat_addr_reg;
    logic [31:0]      lat_wdata_reg;
    logic [7:0]       byte_reg [4];
    logic [CNT_W-1:0] cnt_reg;

    logic        type_ok;
    logic        aligned;
    logic        split_start;
    logic        last_k;
    logic        cap_en;
    logic [1:0]  cap_idx;
    logic [31:0] done_rdata;

    assign misalign_cnt = cnt_reg;

    always_comb begin
        type_ok = 1'b0;
        case (bus.req_type)
            DM_WORD, DM_HALFWORD, DM_BYTE:           type_ok = 1'b1;
            DM_HALFWORD_UNSIGNED, DM_BYTE_UNSIGNED:  type_ok = !bus.req_we;
            default:                                 type_ok = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        case (bus.req_type)
            DM_WORD:                           aligned = (bus.req_addr[1:0] == 2'b00);
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: aligned = !bus.req_addr[0];
            default:                           aligned = 1'b1;
        endcase
    end

    assign split_start = (state_reg == ST_IDLE) && bus.req_valid && type_ok && !aligned;
    assign last_k      = (lat_type_reg == DM_WORD) ? (k_reg == 2'd3) : (k_reg == 2'd1);

    // Load bytes land in the buffer on the edge that ends their issue cycle.
    assign cap_en  = (split_start && !bus.req_we) || ((state_reg == ST_SPLIT) && !lat_we_reg);
    assign cap_idx = (state_reg == ST_IDLE) ? 2'd0 : k_reg;

    always_comb begin
        done_rdata = 32'd0;
        if (!lat_we_reg) begin
            case (lat_type_reg)
                DM_WORD:     done_rdata = {byte_reg[3], byte_reg[2], byte_reg[1], byte_reg[0]};
                DM_HALFWORD: done_rdata = {{16{byte_reg[1][7]}}, byte_reg[1], byte_reg[0]};
                default:     done_rdata = {16'd0, byte_reg[1], byte_reg[0]};
            endcase
        end
    end

    always_comb begin
        bus.dm_we      = 1'b0;
        bus.dm_type    = bus.req_type;
        bus.dm_addr    = bus.req_addr;
        bus.dm_din     = bus.req_wdata;
        bus.stall      = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'd0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (!type_ok) begin
                        bus.resp_valid = 1'b1;
                    end else if (aligned) begin
                        bus.dm_we      = bus.req_we;
                        bus.resp_valid = 1'b1;
                        bus.resp_rdata = bus.req_we ? 32'd0 : bus.dm_dout;
                    end else begin
                        bus.dm_type = bus.req_we ? DM_BYTE : DM_BYTE_UNSIGNED;
                        bus.dm_din  = {24'd0, bus.req_wdata[7:0]};
                        bus.dm_we   = bus.req_we;
                        bus.stall   = 1'b1;
                    end
                end
            end
            ST_SPLIT: begin
                bus.dm_addr = lat_addr_reg + {30'd0, k_reg};
                bus.dm_type = lat_we_reg ? DM_BYTE : DM_BYTE_UNSIGNED;
                bus.dm_din  = {24'd0, lat_wdata_reg[{k_reg, 3'b000} +: 8]};
                bus.dm_we   = lat_we_reg;
                bus.stall   = 1'b1;
            end
            ST_DONE: begin
                bus.dm_addr    = lat_addr_reg;
                bus.dm_type    = lat_type_reg;
                bus.dm_din     = lat_wdata_reg;
                bus.resp_valid = 1'b1;
                bus.resp_rdata = done_rdata;
            end
            default: ;
        endcase
        // Reset must never let a write or a response escape, even mid-split.
        if (!rstn) begin
            bus.dm_we      = 1'b0;
            bus.stall      = 1'b0;
            bus.resp_valid = 1'b0;
            bus.resp_rdata = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            k_reg         <= 2'd0;
            lat_we_reg    <= 1'b0;
            lat_type_reg  <= DM_WORD;
            lat_addr_reg  <= 32'd0;
            lat_wdata_reg <= 32'd0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (split_start) begin
                        lat_we_reg    <= bus.req_we;
                        lat_type_reg  <= bus.req_type;
                        lat_addr_reg  <= bus.req_addr;
                        lat_wdata_reg <= bus.req_wdata;
                        k_reg         <= 2'd1;
                        state_reg     <= ST_SPLIT;
                        if (cnt_reg != '1) begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                ST_SPLIT: begin
                    if (last_k) begin
                        k_reg     <= 2'd0;
                        state_reg <= ST_DONE;
                    end else begin
                        k_reg <= k_reg + 2'd1;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (!rstn) begin
                byte_reg[gi] <= 8'd0;
            end else if (cap_en && (cap_idx == 2'(gi))) begin
                byte_reg[gi] <= bus.dm_dout[7:0];
            end
        end
    end
endmodule

// File: doc/lsu_split.md
# lsu_split

Load/store access unit sitting directly upstream of the 32-bit data memory in the MEM stage. It takes the EX/MEM load/store request and drives the data memory's write-enable, access-type, address and write-data inputs. Naturally aligned accesses pass through in the same cycle. Misaligned halfword/word accesses are split into sequential byte accesses under a small FSM, with a pipeline stall, reassembly and sign extension of load data, and a saturating misalignment counter.

## Interface
Parameters:
- CNT_W, 16, width of misaligned-access counter

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  MEM-stage load/store request present
- req_we  in  1  1 = store, 0 = load
- req_type  in  3  access type, `DM_*` encodings from ctrl_encode_def.v
- req_addr  in  32  byte address from ALU
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold IF..MEM; request inputs must stay stable while high
- resp_valid  out  1  access complete this cycle
- resp_rdata  out  32  load result, extended per req_type; 0 for stores
- dm_we  out  1  to data memory DMWr
- dm_type  out  3  to data memory DMType
- dm_addr  out  32  to data memory addr
- dm_din  out  32  to data memory din
- dm_dout  in  32  from data memory dout (combinational read)
- misalign_cnt  out  CNT_W  count of split accesses, saturating

## Operation
- Legal types: loads use WORD, HALFWORD, HALFWORD_UNSIGNED, BYTE, BYTE_UNSIGNED. Stores use WORD, HALFWORD, BYTE. Any other combination is invalid.
- Aligned means: BYTE always; halfword with addr[0]=0; WORD with addr[1:0]=00.
- FSM states: IDLE, SPLIT, DONE.
- IDLE, req_valid=0:
  - dm_we=0, stall=0, resp_valid=0.
  - dm_addr/dm_type/dm_din still mirror req_*.
- IDLE, valid and aligned: pure pass-through.
  - dm_* = req_*, dm_we=req_we, resp_valid=1, stall=0.
  - resp_rdata = dm_dout for loads, 0 for stores.
- IDLE, invalid: dm_we=0, resp_valid=1, resp_rdata=0, stall=0, no count.
- IDLE, valid and misaligned:
  - N = 2 (halfword) or 4 (word).
  - Latch request; issue byte k=0 this cycle.
  - stall=1; go to SPLIT with k=1; misalign_cnt += 1, saturating at all-ones.
- Byte k access:
  - dm_addr = req_addr + k, modulo 2^32 (0xFFFFFFFF+1 wraps to 0).
  - Store: dm_type=DM_BYTE, dm_din={24'b0, wdata[8k+7:8k]}, dm_we=1.
  - Load: dm_type=DM_BYTE_UNSIGNED, dm_we=0; dm_dout[7:0] captured into buffer byte k at the clock edge.
- SPLIT:
  - Issues byte k from the latched request (req_* ignored); stall=1.
  - k increments each cycle; after k=N-1, go to DONE.
- DONE: dm_we=0, stall=0, resp_valid=1.
  - Word load: resp_rdata = assembled buffer, little-endian, byte 0 at bits 7:0.
  - HALFWORD load: buffer[15:0] sign-extended from bit 15.
  - HALFWORD_UNSIGNED load: buffer[15:0] zero-extended.
  - Store: resp_rdata=0.
  - req_* are ignored (they still hold the completed request and are not reissued). Next state IDLE.

## Timing
- Reset (rstn=0 at rising edge):
  - state=IDLE, k=0, buffer=0, misalign_cnt=0.
  - While rstn=0, outputs are forced: dm_we=0, stall=0, resp_valid=0, resp_rdata=0.
- Aligned latency: 0 cycles, combinational; no stall.
- Misaligned latency:
  - Halfword: 2 issue cycles + DONE; stall high 2 cycles; resp_valid in cycle 2.
  - Word: 4 issue cycles + DONE; stall high 4 cycles; resp_valid in cycle 4. Cycle 0 is the request cycle.
- Each split byte write commits at the rising edge ending its issue cycle.
- Reset mid-split: abort to IDLE; no further bytes are issued. Bytes already written stay in memory; no response is produced.
- misalign_cnt increments only on the IDLE→SPLIT edge. It holds at 2^CNT_W−1.

## Test plan
- Aligned SW 0xA1B2C3D4 @0x10, then LW @0x10:
  - dm_we=1 same cycle, stall never high.
  - LW resp_rdata=0xA1B2C3D4 same cycle.
- Misaligned SW 0x11223344 @0x21:
  - stall high 4 cycles; byte writes 0x44/0x33/0x22/0x11 to 0x21..0x24 in order.
  - Then LW @0x21 returns 0x11223344 in cycle 4; misalign_cnt=2.
- Byte 0x80 @0x33, byte 0xFF @0x34:
  - LH @0x33 → 0xFFFFFF80 after stall of 2 cycles.
  - LHU @0x33 → 0x0000FF80.
- Invalid store type DM_BYTE_UNSIGNED with valid=1:
  - dm_we=0, resp_valid=1, resp_rdata=0, counter unchanged.
- Misaligned SW @0x41, rstn low in cycle 2:
  - Only bytes 0x41 and 0x42 written.
  - Next cycle state IDLE, stall=0, misalign_cnt=0.
- CNT_W=2, issue 5 misaligned accesses:
  - misalign_cnt reads 1, 2, 3, 3, 3.
